// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one carry-lookahead adder between two requesters
module carry_lookahead_adder #(
    parameter int n = 64
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n:0]   result
);
    localparam int NB = (n + 3) / 4;
    localparam int NP = NB * 4;

    logic [NP-1:0] ap;
    logic [NP-1:0] bp;
    logic [NP-1:0] p;
    logic [NP-1:0] g;
    logic [NP:0]   c;
    logic [NB:0]   bc;
    logic [NB-1:0] blk_g;
    logic [NB-1:0] blk_p;

    // 4-bit groups: group generate/propagate chain the group carries, bits ripple inside a group
    always_comb begin
        ap = '0;
        bp = '0;
        ap[n-1:0] = a;
        bp[n-1:0] = b;
        p = ap ^ bp;
        g = ap & bp;
        bc = '0;
        c = '0;
        blk_g = '0;
        blk_p = '0;
        bc[0] = cin;
        for (int j = 0; j < NB; j++) begin
            blk_g[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            blk_p[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
            bc[j+1] = blk_g[j] | (blk_p[j] & bc[j]);
        end
        for (int j = 0; j < NB; j++) begin
            c[4*j] = bc[j];
            for (int k = 0; k < 3; k++) begin
                c[4*j+k+1] = g[4*j+k] | (p[4*j+k] & c[4*j+k]);
            end
        end
        c[NP] = bc[NB];
        result = {c[n], p[n-1:0] ^ c[n-1:0]};
    end
endmodule

module adder_arbiter #(
    parameter int n  = 64,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [n-1:0]  req0_a,
    input  logic [n-1:0]  req0_b,
    input  logic          req0_cin,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [n-1:0]  req1_a,
    input  logic [n-1:0]  req1_b,
    input  logic          req1_cin,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [n-1:0]  rsp_sum,
    output logic          rsp_cout,
    output logic          rsp_id,
    output logic          busy,
    output logic [CW-1:0] gnt_cnt0,
    output logic [CW-1:0] gnt_cnt1
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state_q, state_d;
    logic          exec_ph_q, exec_ph_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic [n-1:0]  op_a_q, op_a_d;
    logic [n-1:0]  op_b_q, op_b_d;
    logic          op_cin_q, op_cin_d;
    logic          op_id_q, op_id_d;
    logic [n:0]    res_q, res_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [n-1:0]  rsp_sum_q, rsp_sum_d;
    logic          rsp_cout_q, rsp_cout_d;
    logic          rsp_id_q, rsp_id_d;
    logic [CW-1:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [CW-1:0] gnt_cnt1_q, gnt_cnt1_d;

    logic          gnt0;
    logic          gnt1;
    logic          accept;
    logic [n:0]    add_result;

    carry_lookahead_adder #(.n(n)) u_cla (
        .a      (op_a_q),
        .b      (op_b_q),
        .cin    (op_cin_q),
        .result (add_result)
    );

    assign gnt0   = req0_valid && (!req1_valid || !rr_ptr_q);
    assign gnt1   = req1_valid && (!req0_valid || rr_ptr_q);
    assign accept = (state_q == IDLE) && (gnt0 || gnt1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // EXEC spans two cycles: capture the adder result, then publish it on the response port
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: if (exec_ph_q) state_d = RESP;
            RESP: if (rsp_valid_q && rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state_q == IDLE) && gnt0;
        req1_ready = (state_q == IDLE) && gnt1;
        busy       = (state_q != IDLE);
    end

    always_comb begin
        exec_ph_d   = (state_q == EXEC) && !exec_ph_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_cin_d    = op_cin_q;
        op_id_d     = op_id_q;
        res_d       = res_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
        gnt_cnt0_d  = gnt_cnt0_q;
        gnt_cnt1_d  = gnt_cnt1_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_a_d   = gnt1 ? req1_a : req0_a;
                    op_b_d   = gnt1 ? req1_b : req0_b;
                    op_cin_d = gnt1 ? req1_cin : req0_cin;
                    op_id_d  = gnt1;
                    rr_ptr_d = ~gnt1;
                    if (gnt1 && gnt_cnt1_q != {CW{1'b1}}) gnt_cnt1_d = gnt_cnt1_q + CW'(1);
                    if (gnt0 && gnt_cnt0_q != {CW{1'b1}}) gnt_cnt0_d = gnt_cnt0_q + CW'(1);
                end
            end
            EXEC: begin
                if (!exec_ph_q) begin
                    res_d = add_result;
                end else begin
                    rsp_sum_d   = res_q[n-1:0];
                    rsp_cout_d  = res_q[n];
                    rsp_id_d    = op_id_q;
                    rsp_valid_d = 1'b1;
                end
            end
            RESP: if (rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exec_ph_q   <= 1'b0;
            rr_ptr_q    <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_cin_q    <= 1'b0;
            op_id_q     <= 1'b0;
            res_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= 1'b0;
            gnt_cnt0_q  <= '0;
            gnt_cnt1_q  <= '0;
        end else begin
            exec_ph_q   <= exec_ph_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_cin_q    <= op_cin_d;
            op_id_q     <= op_id_d;
            res_q       <= res_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
            gnt_cnt0_q  <= gnt_cnt0_d;
            gnt_cnt1_q  <= gnt_cnt1_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
    assign gnt_cnt0  = gnt_cnt0_q;
    assign gnt_cnt1  = gnt_cnt1_q;
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one carry_lookahead_adder instance (n-bit, cin, (n+1)-bit result) between two requesters.
- Round-robin grant with valid/ready on request and response channels; one add in flight at a time.
- Operands and result are registered, so the adder's combinational path sits between two flop stages.
- Sits between issue logic and the shared datapath adder; also keeps per-requester grant counters.

Parameters:
- n, 64, operand width; passed to the carry_lookahead_adder instance.
- CW, 16, width of the saturating per-requester grant counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 has an add pending.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a  in  n  operand A, requester 0.
- req0_b  in  n  operand B, requester 0.
- req0_cin  in  1  carry-in, requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_sum  out  n  low n bits of A+B+cin.
- rsp_cout  out  1  bit n of A+B+cin.
- rsp_id  out  1  requester that issued the add.
- busy  out  1  high whenever state is not IDLE.
- gnt_cnt0  out  CW  grants issued to requester 0, saturating.
- gnt_cnt1  out  CW  grants issued to requester 1, saturating.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, rr_ptr=0 (requester 0 has priority).
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0, gnt_cnt0=0, gnt_cnt1=0.
  - Operand registers cleared.
  - Reset overrides every other event in the same cycle; an add in flight is discarded and no response is produced.
- FSM states:
  - IDLE: reqX_ready is combinational and high only for the granted requester.
    - Grant rule: if exactly one reqX_valid is high, that requester is granted. If both are high, requester rr_ptr is granted.
    - On an accepted handshake (valid and ready both high): latch a, b, cin and the id into operand registers; rr_ptr <= ~granted id; increment that requester's grant counter (holds at all-ones); go to EXEC.
    - With no valid request, stay in IDLE.
  - EXEC: both req_ready are low. The adder evaluates the registered operands. At the edge: rsp_sum <= result[n-1:0], rsp_cout <= result[n], rsp_id <= latched id, rsp_valid <= 1; go to RESP.
  - RESP: rsp_valid=1, and rsp_sum/rsp_cout/rsp_id are held stable until rsp_valid && rsp_ready.
    - On that handshake edge: rsp_valid <= 0; go to IDLE.
    - No new request is accepted in that same cycle.
- Latency and throughput:
  - Accept at edge k; rsp_valid is visible after edge k+2.
  - With rsp_ready tied high, the response handshake completes at edge k+3. The next accept is possible at edge k+4, so peak throughput is 1 add per 4 cycles.
- Arithmetic: modulo 2^(n+1) with no overflow flag. rsp_cout is the only carry indication.
- Requester-side rules:
  - reqX_a, reqX_b and reqX_cin are sampled only on the accept edge.
  - Deasserting reqX_valid before it is accepted is legal (no stickiness required).
  - A request that is not granted simply waits.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…
- busy = (state != IDLE).

Test Plan:
- Single add: req0 a=64, b=64, cin=0; rsp_ready=1 -> rsp_sum=128, rsp_cout=0, rsp_id=0, rsp_valid rises 2 edges after accept; gnt_cnt0=1.
- Large values: req1 a=1000000000, b=1000000000 -> rsp_sum=2000000000, rsp_id=1. Follow-ups on req0: a=123, b=73 -> 196; a=246, b=562, cin=1 -> 809.
- Carry out: a=0xFFFFFFFFFFFFFFFF, b=1, cin=0 -> rsp_sum=0, rsp_cout=1.
- Arbitration: both valid continuously for 4 transactions, with req0 a=1,b=1 and req1 a=2,b=2 -> rsp_id sequence 0,1,0,1; sums 2,4,2,4; gnt_cnt0=gnt_cnt1=2; a non-granted req_ready is never high.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_sum, rsp_cout and rsp_id stay stable, busy=1, both req_ready stay 0. Raise rsp_ready -> handshake, then IDLE the next cycle.
- Reset mid-operation: assert rst in EXEC -> next edge: state IDLE, rsp_valid=0, counters=0, no response ever emitted for that add; the next request completes normally with requester 0 priority.
